xor_cc2p: RTL

//   Keystream consumer placed directly downstream of the 128-bit keystream buffer.

---
 rtl/xor_cc2p.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/xor_cc2p.sv
// rtl/xor_cc2p.sv - keystream consumer: derives the Poly1305 key from block 0, XORs plaintext into ciphertext
module xor_cc2p #(
    parameter int LEN_W = 38
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_start,
    input  logic [127:0]       i_pt_data,
    input  logic               i_pt_vld,
    input  logic               i_pt_last,
    input  logic [4:0]         i_pt_bytes,
    output logic               o_pt_rdy,
    input  logic [127:0]       i_ks_data,
    input  logic               i_ks_empty,
    output logic               o_ks_rd,
    output logic [127:0]       o_ct_data,
    output logic               o_ct_vld,
    output logic               o_ct_last,
    output logic [4:0]         o_ct_bytes,
    input  logic               i_ct_rdy,
    output logic [255:0]       o_pkey,
    output logic               o_pkey_vld,
    output logic [LEN_W-1:0]   o_len,
    output logic               o_busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KEY0  = 3'd1,
        S_KEY1  = 3'd2,
        S_SKIP0 = 3'd3,
        S_SKIP1 = 3'd4,
        S_DATA  = 3'd5
    } state_t;

    state_t             state_q;
    logic [127:0]       ct_data_q;
    logic               ct_vld_q;
    logic               ct_last_q;
    logic [4:0]         ct_bytes_q;
    logic [255:0]       pkey_q;
    logic               pkey_vld_q;
    logic [LEN_W-1:0]   len_q;

    logic               in_key;
    logic               pt_rdy;
    logic               accept;
    logic [4:0]         nbytes;
    logic [127:0]       byte_mask;
    logic [127:0]       ct_data_d;
    logic [LEN_W-1:0]   len_d;

    // The four words of keystream block 0 are consumed without any plaintext.
    assign in_key = (state_q == S_KEY0) || (state_q == S_KEY1) ||
                    (state_q == S_SKIP0) || (state_q == S_SKIP1);

    // The output register may refill in the same cycle its current word leaves.
    assign pt_rdy = (state_q == S_DATA) && !i_ks_empty && (!ct_vld_q || i_ct_rdy);
    assign accept = pt_rdy && i_pt_vld;

    // Out-of-range byte counts on the last word fall back to a full word.
    assign nbytes = (i_pt_last && (i_pt_bytes != 5'd0) && (i_pt_bytes <= 5'd16)) ?
                    i_pt_bytes : 5'd16;

    always_comb begin
        byte_mask = '0;
        for (int k = 0; k < 16; k++) begin
            if (5'(k) < nbytes) begin
                byte_mask[8*k +: 8] = 8'hFF;
            end
        end
    end

    assign ct_data_d = (i_pt_data ^ i_ks_data) & byte_mask;
    assign len_d     = len_q + LEN_W'(nbytes);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_IDLE;
            ct_data_q  <= '0;
            ct_vld_q   <= 1'b0;
            ct_last_q  <= 1'b0;
            ct_bytes_q <= '0;
            pkey_q     <= '0;
            pkey_vld_q <= 1'b0;
            len_q      <= '0;
        end else begin
            if (ct_vld_q && i_ct_rdy) begin
                ct_vld_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        len_q      <= '0;
                        pkey_q     <= '0;
                        pkey_vld_q <= 1'b0;
                        state_q    <= S_KEY0;
                    end
                end
                S_KEY0: begin
                    if (!i_ks_empty) begin
                        pkey_q[127:0] <= i_ks_data;
                        state_q       <= S_KEY1;
                    end
                end
                S_KEY1: begin
                    if (!i_ks_empty) begin
                        pkey_q[255:128] <= i_ks_data;
                        pkey_vld_q      <= 1'b1;
                        state_q         <= S_SKIP0;
                    end
                end
                S_SKIP0: begin
                    if (!i_ks_empty) begin
                        state_q <= S_SKIP1;
                    end
                end
                S_SKIP1: begin
                    if (!i_ks_empty) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        ct_data_q  <= ct_data_d;
                        ct_vld_q   <= 1'b1;
                        ct_last_q  <= i_pt_last;
                        ct_bytes_q <= nbytes;
                        len_q      <= len_d;
                        if (i_pt_last) begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_pt_rdy   = pt_rdy;
    assign o_ks_rd    = (in_key && !i_ks_empty) || accept;
    assign o_ct_data  = ct_data_q;
    assign o_ct_vld   = ct_vld_q;
    assign o_ct_last  = ct_last_q;
    assign o_ct_bytes = ct_bytes_q;
    assign o_pkey     = pkey_q;
    assign o_pkey_vld = pkey_vld_q;
    assign o_len      = len_q;
    assign o_busy     = (state_q != S_IDLE);

endmodule
